// File: rtl/equiv_pkg.sv
// Shared constants, state encoding and LFSR step function for the
// identity-equivalence stimulus driver.
package equiv_pkg;

    // Stimulus slice widths: wire0..wire3 in LFSR bit order, low bits first.
    localparam int W0     = 6;
    localparam int W1     = 22;
    localparam int W2     = 8;
    localparam int W3     = 18;
    localparam int STIM_W = W0 + W1 + W2 + W3;

    // Galois feedback mask for x^64 + x^63 + x^61 + x^60 + 1 (right-shifting form).
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    // An all-zero seed would lock the LFSR, so it is replaced by this value.
    localparam logic [63:0] LFSR_SEED_FALLBACK = 64'h0000_0000_0000_0001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // One Galois step: shift right, fold taps back in when a 1 falls out.
    function automatic logic [63:0] lfsr_next(input logic [63:0] s);
        logic [63:0] r;
        r = {1'b0, s[63:1]};
        if (s[0]) begin
            r = r ^ LFSR_TAPS;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/equiv_lfsr64.sv
// 64-bit Galois LFSR with seed load (zero seed mapped to a non-zero fallback)
// and a single-step enable.
module equiv_lfsr64
    import equiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        srst,
    input  logic        load,
    input  logic [63:0] seed,
    input  logic        step,
    output logic [63:0] state
);

    logic [63:0] state_r;

    // LFSR state register: load has priority over step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= LFSR_SEED_FALLBACK;
        end else if (srst) begin
            state_r <= LFSR_SEED_FALLBACK;
        end else if (load) begin
            state_r <= (seed == 64'd0) ? LFSR_SEED_FALLBACK : seed;
        end else if (step) begin
            state_r <= lfsr_next(state_r);
        end else begin
            state_r <= state_r;
        end
    end

    assign state = state_r;

endmodule

// File: rtl/equiv_stim_driver.sv
// Stimulus/checker end of the identity-equivalence harness. Drives LFSR
// vectors onto wire0..wire3, compares y_1/y_2 LAT cycles later, counts
// mismatches and reports a pass/fail verdict when the run drains.
module equiv_stim_driver
    import equiv_pkg::*;
#(
    parameter int LAT       = 1,
    parameter bit STOP_FAIL = 1'b0,
    parameter int YW        = 91
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          srst,
    input  logic          start,
    input  logic [63:0]   seed,
    input  logic [31:0]   num_vec,
    output logic [W0-1:0] wire0,
    output logic [W1-1:0] wire1,
    output logic [W2-1:0] wire2,
    output logic [W3-1:0] wire3,
    input  logic [YW-1:0] y_1,
    input  logic [YW-1:0] y_2,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [15:0]   fail_cnt,
    output logic          first_fail_vld,
    output logic [31:0]   first_fail_idx
);

    // Only the tail stage may still be valid for the pipe to be empty after this edge.
    localparam logic [LAT-1:0] TAIL_MASK = LAT'(1'b1) << (LAT - 1);

    state_e        state_r;
    state_e        state_next_s;
    logic [31:0]   d_idx_r;
    logic [31:0]   num_vec_r;
    logic [LAT-1:0] pipe_vld_r;
    logic [31:0]   pipe_idx_r [LAT];

    logic [W0-1:0] wire0_r;
    logic [W1-1:0] wire1_r;
    logic [W2-1:0] wire2_r;
    logic [W3-1:0] wire3_r;
    logic          busy_r;
    logic          done_r;
    logic          pass_r;
    logic [15:0]   fail_cnt_r;
    logic          ffv_r;
    logic [31:0]   ffi_r;

    logic [63:0]   lfsr_state_s;
    logic          unused_lfsr_hi_s;
    logic          start_acc_s;
    logic          drive_s;
    logic          mis_s;
    logic          pipe_drained_s;
    logic          last_drive_s;
    logic [15:0]   fail_cnt_next_s;
    logic          ffv_next_s;
    logic [31:0]   ffi_next_s;

    equiv_lfsr64 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .srst  (srst),
        .load  (start_acc_s),
        .seed  (seed),
        .step  (drive_s),
        .state (lfsr_state_s)
    );

    // Bits above the stimulus slice only feed back into the LFSR itself.
    assign unused_lfsr_hi_s = ^lfsr_state_s[63:STIM_W];

    // Per-cycle control: start acceptance, vector drive and mismatch detection.
    always_comb begin
        start_acc_s    = 1'b0;
        drive_s        = 1'b0;
        // Case equality so an x/z on either output counts as a mismatch in sim.
        mis_s          = pipe_vld_r[LAT-1] && (y_1 !== y_2);
        pipe_drained_s = ((pipe_vld_r & ~TAIL_MASK) == {LAT{1'b0}});
        last_drive_s   = (d_idx_r == (num_vec_r - 32'd1));
        case (state_r)
            IDLE, DONE: start_acc_s = start;
            RUN:        drive_s     = !(STOP_FAIL && mis_s);
            default:    drive_s     = 1'b0;
        endcase
    end

    // Next-state logic; a run with no vectors completes immediately.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_next_s = (num_vec == 32'd0) ? DONE : RUN;
                end else begin
                    state_next_s = state_r;
                end
            end
            RUN: begin
                if (STOP_FAIL && mis_s) begin
                    state_next_s = DRAIN;
                end else if (last_drive_s) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN: begin
                if (pipe_drained_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Mismatch bookkeeping: saturating count and first failing index.
    always_comb begin
        fail_cnt_next_s = fail_cnt_r;
        ffv_next_s      = ffv_r;
        ffi_next_s      = ffi_r;
        if (start_acc_s) begin
            fail_cnt_next_s = 16'd0;
            ffv_next_s      = 1'b0;
            ffi_next_s      = 32'd0;
        end else if (mis_s) begin
            if (fail_cnt_r != 16'hFFFF) begin
                fail_cnt_next_s = fail_cnt_r + 16'd1;
            end else begin
                fail_cnt_next_s = fail_cnt_r;
            end
            if (!ffv_r) begin
                ffv_next_s = 1'b1;
                ffi_next_s = pipe_idx_r[LAT-1];
            end else begin
                ffv_next_s = ffv_r;
                ffi_next_s = ffi_r;
            end
        end else begin
            fail_cnt_next_s = fail_cnt_r;
        end
    end

    // FSM state, drive counter, stimulus and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            d_idx_r    <= 32'd0;
            num_vec_r  <= 32'd0;
            wire0_r    <= {W0{1'b0}};
            wire1_r    <= {W1{1'b0}};
            wire2_r    <= {W2{1'b0}};
            wire3_r    <= {W3{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            fail_cnt_r <= 16'd0;
            ffv_r      <= 1'b0;
            ffi_r      <= 32'd0;
        end else if (srst) begin
            state_r    <= IDLE;
            d_idx_r    <= 32'd0;
            num_vec_r  <= 32'd0;
            wire0_r    <= {W0{1'b0}};
            wire1_r    <= {W1{1'b0}};
            wire2_r    <= {W2{1'b0}};
            wire3_r    <= {W3{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            fail_cnt_r <= 16'd0;
            ffv_r      <= 1'b0;
            ffi_r      <= 32'd0;
        end else begin
            state_r    <= state_next_s;
            busy_r     <= (state_next_s == RUN) || (state_next_s == DRAIN);
            done_r     <= (state_next_s == DONE);
            pass_r     <= (state_next_s == DONE) && (fail_cnt_next_s == 16'd0);
            fail_cnt_r <= fail_cnt_next_s;
            ffv_r      <= ffv_next_s;
            ffi_r      <= ffi_next_s;
            if (start_acc_s) begin
                num_vec_r <= num_vec;
                d_idx_r   <= 32'd0;
            end else if (drive_s) begin
                d_idx_r   <= d_idx_r + 32'd1;
            end else begin
                d_idx_r   <= d_idx_r;
            end
            if (drive_s) begin
                wire0_r <= lfsr_state_s[W0-1:0];
                wire1_r <= lfsr_state_s[W0+W1-1:W0];
                wire2_r <= lfsr_state_s[W0+W1+W2-1:W0+W1];
                wire3_r <= lfsr_state_s[STIM_W-1:W0+W1+W2];
            end else begin
                wire0_r <= wire0_r;
                wire1_r <= wire1_r;
                wire2_r <= wire2_r;
                wire3_r <= wire3_r;
            end
        end
    end

    // Check pipe: {valid, index} launched with each drive, compared at the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_r <= {LAT{1'b0}};
            for (int i = 0; i < LAT; i++) begin
                pipe_idx_r[i] <= 32'd0;
            end
        end else if (srst) begin
            pipe_vld_r <= {LAT{1'b0}};
            for (int i = 0; i < LAT; i++) begin
                pipe_idx_r[i] <= 32'd0;
            end
        end else begin
            pipe_vld_r[0] <= drive_s;
            pipe_idx_r[0] <= d_idx_r;
            for (int i = 1; i < LAT; i++) begin
                pipe_vld_r[i] <= pipe_vld_r[i-1];
                pipe_idx_r[i] <= pipe_idx_r[i-1];
            end
        end
    end

    assign wire0          = wire0_r;
    assign wire1          = wire1_r;
    assign wire2          = wire2_r;
    assign wire3          = wire3_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign fail_cnt       = fail_cnt_r;
    assign first_fail_vld = ffv_r;
    assign first_fail_idx = ffi_r;

endmodule
